sr_pq_rd: RTL and testbench

- Synthesizable shift-register priority queue; the responder end of the pq_rd_if protocol (enq/deq/replace commands in, head key/value out).
- Lower key means higher priority.
- Head entry is always visible on kvo. One command is accepted per clock with no stall.
- Sits alongside the register-array PQ as an alternative HWPQ implementation for area/timing comparison; shares pq_pkg and pq_rd_if.

---
 rtl/pq_pkg.sv | 25 ++
 rtl/sr_pq_cell.sv | 51 +++++
 rtl/sr_pq_rd.sv | 111 +++++++++++
 tb/tb_sr_pq_rd.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// Shared types for the hardware priority queues: key/value widths, the
// {key,val} entry layout, the {valid,entry} cell layout and the per-cycle command.
package pq_pkg;

  localparam int KEY_WIDTH = 8;
  localparam int VAL_WIDTH = 8;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;

  typedef struct packed {
    logic valid;
    kv_t  kv;
  } cell_t;

  typedef enum logic [1:0] {
    CMD_HOLD    = 2'd0,
    CMD_ENQ     = 2'd1,
    CMD_DEQ     = 2'd2,
    CMD_REPLACE = 2'd3
  } cmd_t;

endpackage

// File: rtl/sr_pq_cell.sv
// One storage cell of the shift-register priority queue. It holds {valid,key,val}
// and picks its next value from: itself, kvi, the upper neighbour or the lower neighbour.
module sr_pq_cell
  import pq_pkg::*;
#(
  parameter int KW      = 8,
  parameter int VW      = 8,
  parameter bit IS_HEAD = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  cmd_t             cmd_i,
  input  logic             le_up_i,
  input  logic             le_self_i,
  input  logic             le_dn_i,
  input  logic [KW+VW:0]   up_i,
  input  logic [KW+VW:0]   dn_i,
  input  logic [KW+VW-1:0] kvi_i,
  output logic [KW+VW:0]   cell_o
);

  logic [KW+VW:0] cell_q, cell_d;

  // le bits are a prefix of ones, so each cell finds the insert point from its
  // own bit and one neighbour; on REPLACE the view is the already-shifted-up queue.
  always_comb begin
    cell_d = cell_q;
    unique case (cmd_i)
      CMD_ENQ: begin
        if (!le_self_i) begin
          if (IS_HEAD || le_up_i) cell_d = {1'b1, kvi_i};
          else                    cell_d = up_i;
        end
      end
      CMD_DEQ: cell_d = dn_i;
      CMD_REPLACE: begin
        if (le_dn_i)                    cell_d = dn_i;
        else if (IS_HEAD || le_self_i)  cell_d = {1'b1, kvi_i};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cell_q <= '0;
    else         cell_q <= cell_d;
  end

  assign cell_o = cell_q;

endmodule

// File: rtl/sr_pq_rd.sv
// Shift-register priority queue, responder side of pq_rd_if (lowest key at head).
// Build option PQ_FULL_EVICT_EN: ENQ on a full queue evicts the tail if the new key is smaller.
module sr_pq_rd
  import pq_pkg::*;
#(
  parameter int PQ_DEPTH  = 8,
  parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
  parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enq,
  input  logic                           deq,
  input  logic                           replace,
  input  logic [KEY_WIDTH+VAL_WIDTH-1:0] kvi,
  output logic [KEY_WIDTH+VAL_WIDTH-1:0] kvo,
  output logic                           ovalid,
  output logic                           empty,
  output logic                           full,
  output logic                           drop
);

  localparam int CW = KEY_WIDTH + VAL_WIDTH + 1;

  logic [CW-1:0]        cells_q [PQ_DEPTH];
  logic [CW-1:0]        up_w    [PQ_DEPTH];
  logic [CW-1:0]        dn_w    [PQ_DEPTH];
  logic [PQ_DEPTH-1:0]  le;
  logic [PQ_DEPTH-1:0]  le_up_w;
  logic [PQ_DEPTH-1:0]  le_dn_w;
  logic [KEY_WIDTH-1:0] kvi_key;
  cmd_t                 cmd;
  logic                 drop_d, drop_q;

  assign kvi_key = kvi[KEY_WIDTH+VAL_WIDTH-1:VAL_WIDTH];

  always_comb begin
    le = '0;
    for (int i = 0; i < PQ_DEPTH; i++) begin
      le[i] = cells_q[i][CW-1] &&
              (cells_q[i][KEY_WIDTH+VAL_WIDTH-1:VAL_WIDTH] <= kvi_key);
    end
  end

  always_comb begin
    cmd    = CMD_HOLD;
    drop_d = 1'b0;
    if (replace || (enq && deq)) begin
      cmd = CMD_REPLACE;
    end else if (enq) begin
      if (!full) begin
        cmd = CMD_ENQ;
      end else begin
        drop_d = 1'b1;
`ifdef PQ_FULL_EVICT_EN
        // Tail key strictly greater than the new key: shifting pushes the tail out.
        if (!le[PQ_DEPTH-1]) cmd = CMD_ENQ;
`endif
      end
    end else if (deq) begin
      cmd = CMD_DEQ;
    end
  end

  for (genvar g = 0; g < PQ_DEPTH; g++) begin : g_cell
    if (g == 0) begin : g_head
      assign up_w[g]    = '0;
      assign le_up_w[g] = 1'b0;
    end else begin : g_mid
      assign up_w[g]    = cells_q[g-1];
      assign le_up_w[g] = le[g-1];
    end
    if (g == PQ_DEPTH-1) begin : g_tail
      assign dn_w[g]    = '0;
      assign le_dn_w[g] = 1'b0;
    end else begin : g_body
      assign dn_w[g]    = cells_q[g+1];
      assign le_dn_w[g] = le[g+1];
    end

    sr_pq_cell #(
      .KW      (KEY_WIDTH),
      .VW      (VAL_WIDTH),
      .IS_HEAD (g == 0)
    ) u_cell (
      .clk_i     (clk),
      .rst_ni    (rst),
      .cmd_i     (cmd),
      .le_up_i   (le_up_w[g]),
      .le_self_i (le[g]),
      .le_dn_i   (le_dn_w[g]),
      .up_i      (up_w[g]),
      .dn_i      (dn_w[g]),
      .kvi_i     (kvi),
      .cell_o    (cells_q[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) drop_q <= 1'b0;
    else      drop_q <= drop_d;
  end

  // Invalid cells are kept all-zero, so the head register is already 0 when empty.
  assign kvo    = cells_q[0][CW-2:0];
  assign ovalid = cells_q[0][CW-1];
  assign empty  = ~cells_q[0][CW-1];
  assign full   = cells_q[PQ_DEPTH-1][CW-1];
  assign drop   = drop_q;

endmodule

// File: tb/tb_sr_pq_rd.sv
// Directed, table-driven bench for sr_pq_rd (PQ_DEPTH=8); the full-queue
// sequence follows PQ_FULL_EVICT_EN when it is defined.
module tb_sr_pq_rd;

  localparam int KW = pq_pkg::KEY_WIDTH;
  localparam int VW = pq_pkg::VAL_WIDTH;

  typedef struct {
    logic          rst;
    logic          enq;
    logic          deq;
    logic          rep;
    logic [KW-1:0] key;
    logic [VW-1:0] val;
    logic [KW-1:0] ekey;
    logic [VW-1:0] evl;
    logic          eov;
    logic          efull;
    logic          edrop;
  } vec_t;

  logic clk = 1'b0;
  logic rst, enq, deq, replace;
  logic [KW+VW-1:0] kvi, kvo;
  logic ovalid, empty, full, drop;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  sr_pq_rd #(.PQ_DEPTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .enq     (enq),
    .deq     (deq),
    .replace (replace),
    .kvi     (kvi),
    .kvo     (kvo),
    .ovalid  (ovalid),
    .empty   (empty),
    .full    (full),
    .drop    (drop)
  );

  function automatic vec_t v(input logic r, input logic e, input logic d, input logic p,
                             input int k, input int vl, input int ek, input int ev,
                             input logic eov, input logic ef, input logic ed);
    vec_t t;
    t.rst = r; t.enq = e; t.deq = d; t.rep = p;
    t.key = KW'(k); t.val = VW'(vl); t.ekey = KW'(ek); t.evl = VW'(ev);
    t.eov = eov; t.efull = ef; t.edrop = ed;
    return t;
  endfunction

  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    rst = t.rst; enq = t.enq; deq = t.deq; replace = t.rep; kvi = {t.key, t.val};
    @(posedge clk);
    #1;
    n_vec++;
    if (kvo !== {t.ekey, t.evl} || ovalid !== t.eov || empty !== !t.eov ||
        full !== t.efull || drop !== t.edrop) begin
      n_bad++;
      $display("FAIL %s: got kvo=%h ov=%b em=%b fu=%b dr=%b, want kvo=%h ov=%b em=%b fu=%b dr=%b",
               tag, kvo, ovalid, empty, full, drop, {t.ekey, t.evl}, t.eov, !t.eov,
               t.efull, t.edrop);
    end
  endtask

  initial begin
    rst = 1'b0; enq = 1'b0; deq = 1'b0; replace = 1'b0; kvi = '0;

    // reset with enq asserted
    tbl.push_back(v(0,1,0,0, 5,5,  0,0,  0,0,0));
    tbl.push_back(v(0,1,0,0, 5,5,  0,0,  0,0,0));
    // sort
    tbl.push_back(v(1,1,0,0, 8,14, 8,14, 1,0,0));
    tbl.push_back(v(1,1,0,0, 11,11,8,14, 1,0,0));
    tbl.push_back(v(1,1,0,0, 9,9,  8,14, 1,0,0));
    tbl.push_back(v(1,1,0,0, 10,10,8,14, 1,0,0));
    tbl.push_back(v(1,0,1,0, 0,0,  9,9,  1,0,0));
    tbl.push_back(v(1,0,1,0, 0,0,  10,10,1,0,0));
    tbl.push_back(v(1,0,1,0, 0,0,  11,11,1,0,0));
    tbl.push_back(v(1,0,1,0, 0,0,  0,0,  0,0,0));
    // deq on empty
    tbl.push_back(v(1,0,1,0, 3,3,  0,0,  0,0,0));
    // replace
    tbl.push_back(v(1,1,0,0, 8,8,  8,8,  1,0,0));
    tbl.push_back(v(1,1,0,0, 9,9,  8,8,  1,0,0));
    tbl.push_back(v(1,1,0,0, 10,10,8,8,  1,0,0));
    tbl.push_back(v(1,1,0,0, 11,11,8,8,  1,0,0));
    tbl.push_back(v(1,0,0,1, 1,1,  1,1,  1,0,0));
    tbl.push_back(v(1,0,0,1, 12,12,9,9,  1,0,0));
    tbl.push_back(v(1,0,1,0, 0,0,  10,10,1,0,0));
    tbl.push_back(v(1,0,1,0, 0,0,  11,11,1,0,0));
    tbl.push_back(v(1,0,1,0, 0,0,  12,12,1,0,0));
    tbl.push_back(v(1,0,1,0, 0,0,  0,0,  0,0,0));
    // ties keep FIFO order
    tbl.push_back(v(1,1,0,0, 5,1,  5,1,  1,0,0));
    tbl.push_back(v(1,1,0,0, 5,2,  5,1,  1,0,0));
    tbl.push_back(v(1,1,0,0, 5,3,  5,1,  1,0,0));
    tbl.push_back(v(1,0,1,0, 0,0,  5,2,  1,0,0));
    tbl.push_back(v(1,0,1,0, 0,0,  5,3,  1,0,0));
    tbl.push_back(v(1,0,1,0, 0,0,  0,0,  0,0,0));
    // enq+deq together acts as replace
    tbl.push_back(v(1,1,0,0, 4,4,  4,4,  1,0,0));
    tbl.push_back(v(1,1,0,0, 6,6,  4,4,  1,0,0));
    tbl.push_back(v(1,1,1,0, 2,7,  2,7,  1,0,0));
    tbl.push_back(v(1,0,1,0, 0,0,  6,6,  1,0,0));
    tbl.push_back(v(1,0,1,0, 0,0,  0,0,  0,0,0));
    // replace on empty behaves as enq, then idle
    tbl.push_back(v(1,0,0,1, 7,3,  7,3,  1,0,0));
    tbl.push_back(v(1,0,0,0, 0,0,  7,3,  1,0,0));
    tbl.push_back(v(1,0,1,0, 0,0,  0,0,  0,0,0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // fill to full, then overflow
    for (int k = 10; k <= 17; k++)
      apply(v(1,1,0,0, k,k, 10,10, 1,(k == 17),0), $sformatf("fill%0d", k));
`ifdef PQ_FULL_EVICT_EN
    apply(v(1,1,0,0, 3,3,  3,3,   1,1,1), "evict");
    apply(v(1,0,0,0, 0,0,  3,3,   1,1,0), "drop_clr");
    apply(v(1,0,0,1, 20,20,10,10, 1,1,0), "rep_full");
    for (int k = 11; k <= 16; k++)
      apply(v(1,0,1,0, 0,0, k,k, 1,0,0), $sformatf("drain%0d", k));
`else
    apply(v(1,1,0,0, 3,3,  10,10, 1,1,1), "discard");
    apply(v(1,0,0,0, 0,0,  10,10, 1,1,0), "drop_clr");
    apply(v(1,0,0,1, 20,20,11,11, 1,1,0), "rep_full");
    for (int k = 12; k <= 17; k++)
      apply(v(1,0,1,0, 0,0, k,k, 1,0,0), $sformatf("drain%0d", k));
`endif
    apply(v(1,0,1,0, 0,0, 20,20, 1,0,0), "drain20");
    apply(v(1,0,1,0, 0,0, 0,0,   0,0,0), "drained");

    // reset mid-operation wins over commands
    apply(v(1,1,0,0, 1,1, 1,1, 1,0,0), "pre_rst");
    apply(v(0,1,1,0, 2,2, 0,0, 0,0,0), "mid_rst");
    apply(v(1,0,0,0, 0,0, 0,0, 0,0,0), "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
